ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port synchronous word RAM between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Round-robin arbitration, one transaction in flight at a time, fixed 3-cycle latency, out-of-range address trapping.
- Sits between the core's fetch/memory stages and the RAM instance.
- All RAM control outputs are registered.

Parameters:
- DEPTH, 1024: number of 32-bit words implemented in the RAM; word addresses >= DEPTH are out of range.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- p0_req  input  1  port 0 request, held high until p0_done
- p0_we  input  1  port 0 write (1) / read (0), valid with p0_req
- p0_addr  input  30  port 0 word address
- p0_wdata  input  32  port 0 write data
- p0_done  output  1  port 0 one-cycle completion pulse
- p0_err  output  1  port 0 out-of-range flag, valid with p0_done
- p0_rdata  output  32  port 0 read data, valid with p0_done, held until next p0_done
- p1_req, p1_we, p1_addr, p1_wdata, p1_done, p1_err, p1_rdata: same as port 0, for port 1
- ram_addr  output  30  RAM word address
- ram_din  output  32  RAM write data
- ram_re  output  1  RAM read enable
- ram_we  output  1  RAM write enable
- ram_dout  input  32  RAM read data; registered in the RAM, valid the cycle after the ram_re edge

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie.
  - Reset mid-transaction aborts it; no done pulse is ever issued for it.
- States: IDLE -> ACCESS -> WAIT -> IDLE.
- IDLE: eligible requests are pX_req & ~pX_done.
  - This masks the port being acknowledged this cycle, so its still-high req is never re-granted.
  - One eligible: grant it. Both eligible: grant the port != last_grant.
  - On grant, at the edge: latch grant, addr, we, wdata, oor = (addr >= DEPTH); load ram_addr/ram_din; last_grant <= granted port; state <= ACCESS.
  - In-range read: ram_re <= 1. In-range write: ram_we <= 1. Out-of-range: neither.
  - No eligible request: stay in IDLE; RAM enables 0.
- ACCESS: RAM enables are high for exactly this cycle. At the edge: ram_re, ram_we <= 0; state <= WAIT.
- WAIT: ram_dout is valid. At the edge, for the granted port:
  - done <= 1.
  - err <= oor.
  - rdata <= 0 if oor, else <= ram_dout for reads; rdata unchanged for writes.
  - state <= IDLE.
- pX_done is high for exactly one cycle, the IDLE cycle following WAIT. The other port may be granted in that same cycle.
- Latency: req first seen in IDLE cycle N -> ram enable in cycle N+1 -> done in cycle N+3. Peak throughput is one transaction per 3 cycles.
- Requesters must drop req, or present a new request, in the cycle after done. req/addr/we/wdata are sampled only at the grant edge; later changes are ignored.
- Out-of-range writes are dropped. The RAM is never enabled for an out-of-range access.
- ram_re and ram_we are never both high. ram_addr/ram_din hold their last values when the enables are low.
- A request arriving during ACCESS/WAIT waits; it is considered in the next IDLE cycle.

Test Plan:
- Reset, then p0 read addr 0 with RAM word0=32'h00200093 -> ram_re high only in cycle 1 with ram_addr=0; p0_done in cycle 3 with p0_rdata=32'h00200093, p0_err=0.
- p1 write addr 5 wdata 32'hDEADBEEF, then p1 read addr 5 -> ram_we pulse with ram_din=32'hDEADBEEF; the read returns 32'hDEADBEEF; p1_rdata holds that value after p1_req drops.
- p0 and p1 both requesting continuously from reset -> grants alternate p0,p1,p0,p1; each done spaced 3 cycles apart; the port acknowledged is never re-granted in its own done cycle.
- p0 read addr 1024 with DEPTH=1024 -> no ram_re/ram_we pulse; p0_done with p0_err=1, p0_rdata=0. p1 write addr 2000 -> p1_err=1; RAM contents unchanged.
- rst_n low during ACCESS of a p1 read -> all outputs 0 immediately. After release, no p1_done for the aborted request; a re-issued request completes normally with 3-cycle latency.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares a single-port synchronous word RAM between a fetch port (0)
// and a load/store port (1). It runs one transaction at a time with a fixed 3-cycle latency.
module ram_arbiter #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [29:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [29:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_re,
    output logic        ram_we,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_gnt;
    logic        r_we;
    logic        r_oor;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant;
    logic        w_gnt;
    logic        w_we;
    logic        w_oor;
    logic [29:0] w_addr;
    logic [31:0] w_wdata;

    // A port that is being acknowledged this cycle still holds req high; mask it out.
    assign w_elig0 = p0_req & ~p0_done;
    assign w_elig1 = p1_req & ~p1_done;

    assign w_addr  = w_gnt ? p1_addr  : p0_addr;
    assign w_wdata = w_gnt ? p1_wdata : p0_wdata;
    assign w_we    = w_gnt ? p1_we    : p0_we;
    assign w_oor   = {2'b00, w_addr} >= 32'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gnt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_grant = 1'b1;
                    w_gnt   = (w_elig0 & w_elig1) ? ~r_last : w_elig1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_oor    <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_re   <= 1'b0;
            ram_we   <= 1'b0;
            p0_done  <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_done  <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
        end else begin
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gnt    <= w_gnt;
                        r_we     <= w_we;
                        r_oor    <= w_oor;
                        r_last   <= w_gnt;
                        ram_addr <= w_addr;
                        ram_din  <= w_wdata;
                        ram_re   <= ~w_we & ~w_oor;
                        ram_we   <= w_we & ~w_oor;
                    end
                end
                S_ACCESS: begin
                    ram_re <= 1'b0;
                    ram_we <= 1'b0;
                end
                S_WAIT: begin
                    // ram_dout carries the word read during ACCESS.
                    if (r_gnt) begin
                        p1_done <= 1'b1;
                        p1_err  <= r_oor;
                        if (r_oor) begin
                            p1_rdata <= '0;
                        end else if (!r_we) begin
                            p1_rdata <= ram_dout;
                        end
                    end else begin
                        p0_done <= 1'b1;
                        p0_err  <= r_oor;
                        if (r_oor) begin
                            p0_rdata <= '0;
                        end else if (!r_we) begin
                            p0_rdata <= ram_dout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM, a shadow memory model and per-port
// expectation queues that a monitor drains on every done pulse.
module tb_ram_arbiter;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [29:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_done, p0_err, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [29:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_re, ram_we;
    logic [31:0] ram_dout;

    always #5 clk = ~clk;

    ram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_re(ram_re), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] lastr0 = 32'h0;
    logic [31:0] lastr1 = 32'h0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    logic [31:0] last_we_din = 32'h0;
    bit          alt_mode = 1'b0;
    int          last_port = 1;
    int          last_cyc = -1;
    logic        prev_d0 = 1'b0;
    logic        prev_d1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural synchronous RAM: read data is registered on the ram_re edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_re || ram_we) en_cnt <= en_cnt + 1;
        if (ram_we) begin
            mem[ram_addr[9:0]] <= ram_din;
            last_we_din <= ram_din;
        end
        if (ram_re) ram_dout <= mem[ram_addr[9:0]];
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i * 7);
            ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
        end
        mem[0]     = 32'h0020_0093;
        ref_mem[0] = 32'h0020_0093;
    end

    function automatic logic [31:0] all_outs_or();
        return {31'b0, |{p0_done, p0_err, p0_rdata, p1_done, p1_err, p1_rdata,
                         ram_addr, ram_din, ram_re, ram_we}};
    endfunction

    // Expected response from the memory rules: oor -> err, rdata 0; write keeps old rdata.
    task automatic push_exp(input int port, input logic we, input logic [29:0] addr,
                            input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] prev;
        prev = (port == 0) ? lastr0 : lastr1;
        if (int'(addr) >= DEPTH) begin
            e.err = 1'b1;
            e.rdata = 32'h0;
        end else if (we) begin
            ref_mem[addr[9:0]] = wdata;
            e.err = 1'b0;
            e.rdata = prev;
        end else begin
            e.err = 1'b0;
            e.rdata = ref_mem[addr[9:0]];
        end
        if (port == 0) begin
            lastr0 = e.rdata;
            q0.push_back(e);
        end else begin
            lastr1 = e.rdata;
            q1.push_back(e);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [29:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised done.
    task automatic issue(input int port, input logic we, input logic [29:0] addr,
                         input logic [31:0] wdata, input bit chk_lat, input bit drop);
        int  start;
        int  n;
        bit  seen;
        push_exp(port, we, addr, wdata);
        drive(port, 1'b1, we, addr, wdata);
        start = cyc;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = (port == 0) ? p0_done : p1_done;
        end
        if (!seen) chk($sformatf("p%0d_done_timeout", port), 32'd0, 32'd1);
        else if (chk_lat) chk($sformatf("p%0d_latency", port), 32'(cyc - start), 32'd3);
        if (drop) drive(port, 1'b0, 1'b0, 30'h0, 32'h0);
    endtask

    task automatic mon_port(input int port);
        exp_t        e;
        logic        err;
        logic [31:0] rd;
        logic        prev;
        err  = (port == 0) ? p0_err : p1_err;
        rd   = (port == 0) ? p0_rdata : p1_rdata;
        prev = (port == 0) ? prev_d0 : prev_d1;
        chk($sformatf("p%0d_done_one_cycle", port), {31'b0, prev}, 32'd0);
        if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
            chk($sformatf("p%0d_unexpected_done", port), 32'd1, 32'd0);
        end else begin
            e = (port == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("p%0d_err", port), {31'b0, err}, {31'b0, e.err});
            chk($sformatf("p%0d_rdata", port), rd, e.rdata);
        end
        if (alt_mode) begin
            chk("alt_order", 32'(port), 32'(1 - last_port));
            if (last_cyc >= 0) chk("alt_spacing", 32'(cyc - last_cyc), 32'd3);
            last_port = port;
            last_cyc  = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_d0 = 1'b0;
            prev_d1 = 1'b0;
        end else begin
            if (p0_done) mon_port(0);
            if (p1_done) mon_port(1);
            if (ram_re || ram_we) begin
                chk("ram_re_we_exclusive", {31'b0, ram_re & ram_we}, 32'd0);
                chk("ram_enable_in_range", {31'b0, int'(ram_addr) < DEPTH}, 32'd1);
            end
            prev_d0 = p0_done;
            prev_d1 = p1_done;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 30'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 30'h0, 32'h0);
        q0.delete();
        q1.delete();
        lastr0 = 32'h0;
        lastr1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs_zero", all_outs_or(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_port(input int port, input int n, input bit cont);
        logic        we;
        logic [29:0] addr;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = 30'(DEPTH + int'($urandom_range(0, 1000000)));
            else addr = 30'(port * 512 + int'($urandom_range(0, 511)));
            issue(port, we, addr, $urandom, 1'b0, !cont);
            if (!cont) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drive(port, 1'b0, 1'b0, 30'h0, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0;
        int dcount;
        do_reset();

        // First fetch: enable timing and read data of word 0.
        push_exp(0, 1'b0, 30'd0, 32'h0);
        drive(0, 1'b1, 1'b0, 30'd0, 32'h0);
        @(posedge clk); #1;
        chk("t1_ram_re_c1", {31'b0, ram_re}, 32'd1);
        chk("t1_ram_we_c1", {31'b0, ram_we}, 32'd0);
        chk("t1_ram_addr_c1", {2'b0, ram_addr}, 32'd0);
        @(posedge clk); #1;
        chk("t1_ram_re_c2", {31'b0, ram_re}, 32'd0);
        chk("t1_done_c2", {31'b0, p0_done}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done_c3", {31'b0, p0_done}, 32'd1);
        drive(0, 1'b0, 1'b0, 30'h0, 32'h0);
        @(posedge clk); #1;

        // Write then read back on the load/store port.
        issue(1, 1'b1, 30'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("t2_ram_din", last_we_din, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        issue(1, 1'b0, 30'd5, 32'h0, 1'b1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_rdata_hold", p1_rdata, 32'hDEAD_BEEF);

        // Out-of-range accesses never enable the RAM and leave memory untouched.
        en0 = en_cnt;
        issue(0, 1'b0, 30'd1024, 32'h0, 1'b1, 1'b1);
        @(posedge clk); #1;
        issue(1, 1'b1, 30'd2000, 32'h1234_5678, 1'b1, 1'b1);
        chk("t3_no_enable_oor", 32'(en_cnt - en0), 32'd0);
        @(posedge clk); #1;
        issue(1, 1'b0, 30'd976, 32'h0, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Both ports requesting continuously from reset: strict alternation.
        do_reset();
        last_port = 1;
        last_cyc  = -1;
        alt_mode  = 1'b1;
        fork
            run_port(0, 6, 1'b1);
            run_port(1, 6, 1'b1);
        join
        alt_mode = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        // Randomized traffic, ports confined to disjoint address halves plus oor.
        fork
            run_port(0, 30, 1'b0);
            run_port(1, 30, 1'b0);
        join
        repeat (4) begin @(posedge clk); #1; end

        // Reset during ACCESS of a port 1 read aborts it silently.
        drive(1, 1'b1, 1'b0, 30'd7, 32'h0);
        @(posedge clk); #1;
        chk("t5_access_re", {31'b0, ram_re}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs", all_outs_or(), 32'd0);
        q0.delete();
        q1.delete();
        lastr0 = 32'h0;
        lastr1 = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 1'b0, 1'b0, 30'h0, 32'h0);
        dcount = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (p1_done) dcount++;
        end
        chk("t5_no_done_after_abort", 32'(dcount), 32'd0);
        issue(1, 1'b0, 30'd7, 32'h0, 1'b1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
